// File: rtl/auth_pkg.sv
// auth_pkg: shared message types, status codes, FSM states and header layout for the Type-C auth initiator
package auth_pkg;

    // Request and response MessageType codes
    localparam logic [7:0] MT_GET_DIGESTS     = 8'h81;
    localparam logic [7:0] MT_GET_CERTIFICATE = 8'h82;
    localparam logic [7:0] MT_CHALLENGE       = 8'h83;
    localparam logic [7:0] MT_DIGESTS         = 8'h01;
    localparam logic [7:0] MT_CERTIFICATE     = 8'h02;
    localparam logic [7:0] MT_CHALLENGE_AUTH  = 8'h03;
    localparam logic [7:0] MT_ERROR           = 8'h7F;

    // Transaction completion codes
    localparam logic [2:0] STAT_OK          = 3'd0;
    localparam logic [2:0] STAT_TIMEOUT     = 3'd1;
    localparam logic [2:0] STAT_ERROR_RSP   = 3'd2;
    localparam logic [2:0] STAT_BAD_VERSION = 3'd3;
    localparam logic [2:0] STAT_BAD_TYPE    = 3'd4;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_SEND     = 3'd1;
    localparam state_t S_WAIT_RSP = 3'd2;
    localparam state_t S_CHECK    = 3'd3;
    localparam state_t S_DONE     = 3'd4;

    // Header field offsets (each field is one byte)
    localparam int HDR_VER_LSB  = 0;
    localparam int HDR_TYPE_LSB = 8;
    localparam int HDR_P1_LSB   = 16;
    localparam int HDR_P2_LSB   = 24;
    localparam int HDR_W        = 32;

    // Classify a response header; the first failing rule wins
    function automatic logic [2:0] check_header(input logic [HDR_W-1:0] rsp, input logic [7:0] ver,
                                                input logic [7:0] req_type);
        logic [7:0] rsp_ver;
        logic [7:0] rsp_type;
        rsp_ver  = rsp[HDR_VER_LSB +: 8];
        rsp_type = rsp[HDR_TYPE_LSB +: 8];
        return (rsp_ver != ver)                    ? STAT_BAD_VERSION :
               (rsp_type == MT_ERROR)              ? STAT_ERROR_RSP   :
               (rsp_type != (req_type & 8'h7F))    ? STAT_BAD_TYPE    : STAT_OK;
    endfunction

endpackage

// File: rtl/auth_timeout_timer.sv
// auth_timeout_timer: per-attempt response timer that holds at its terminal count
module auth_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count waiting cycles; stop at terminal count so the controller decides what happens next
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !tc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/auth_initiator_ctrl.sv
// auth_initiator_ctrl: Type-C Authentication initiator; sends a request, waits with retry, checks the response.
// Optional build macro AUTH_INIT_STATS_EN adds saturating timeout_total / fail_total counters.
module auth_initiator_ctrl
    import auth_pkg::*;
#(
    parameter int         MSG_W            = 1000,
    parameter int         TIMEOUT_CYCLES   = 1024,
    parameter int         MAX_RETRIES      = 2,
    parameter logic [7:0] PROTOCOL_VERSION = 8'h01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            req_type,
    input  logic [7:0]            req_param1,
    input  logic [7:0]            req_param2,
    input  logic [MSG_W-33:0]     req_payload,
    output logic [MSG_W-1:0]      msg_out,
    output logic                  msg_out_valid,
    input  logic                  msg_out_ready,
    input  logic [MSG_W-1:0]      msg_in,
    input  logic                  msg_in_valid,
    output logic                  msg_in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            status,
    output logic [MSG_W-1:0]      rsp_out,
    output logic [1:0]            attempts
`ifdef AUTH_INIT_STATS_EN
    ,
    output logic [15:0]           timeout_total,
    output logic [15:0]           fail_total
`endif
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    state_t        state;
    logic [RW-1:0] retries;
    logic          tc;
    logic          in_wait;
    logic          timeout_ev;
    logic          can_retry;

    assign in_wait       = (state == S_WAIT_RSP);
    assign timeout_ev    = in_wait && !msg_in_valid && tc;
    assign can_retry     = (retries < RW'(MAX_RETRIES));
    assign msg_out_valid = (state == S_SEND);
    assign msg_in_ready  = in_wait;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    // Timer runs only while waiting for a response and restarts on every entry to WAIT_RSP
    auth_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (!in_wait),
        .enable(in_wait && !msg_in_valid),
        .tc    (tc)
    );

    // Transaction sequencing: latch request, handshake out, wait/retry, classify, report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            msg_out  <= '0;
            retries  <= '0;
            status   <= STAT_OK;
            rsp_out  <= '0;
            attempts <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        msg_out <= {req_payload, req_param2, req_param1, req_type, PROTOCOL_VERSION};
                        retries <= '0;
                        status  <= STAT_OK;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (msg_out_ready)
                        state <= S_WAIT_RSP;
                end
                S_WAIT_RSP: begin
                    if (msg_in_valid) begin
                        rsp_out <= msg_in;
                        state   <= S_CHECK;
                    end else if (timeout_ev && can_retry) begin
                        retries <= retries + 1'b1;
                        state   <= S_SEND;
                    end else if (timeout_ev) begin
                        status   <= STAT_TIMEOUT;
                        attempts <= 2'(retries);
                        state    <= S_DONE;
                    end
                end
                S_CHECK: begin
                    status   <= check_header(rsp_out[HDR_W-1:0], PROTOCOL_VERSION, msg_out[HDR_TYPE_LSB +: 8]);
                    attempts <= 2'(retries);
                    state    <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AUTH_INIT_STATS_EN
    // Lifetime statistics, saturating, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_total <= 16'd0;
            fail_total    <= 16'd0;
        end else begin
            if (timeout_ev && timeout_total != 16'hFFFF)
                timeout_total <= timeout_total + 16'd1;
            if (done && status != STAT_OK && fail_total != 16'hFFFF)
                fail_total <= fail_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_auth_initiator_ctrl.sv
// tb_auth_initiator_ctrl: randomized scoreboard bench for the auth initiator controller
`timescale 1ns/1ps
module tb_auth_initiator_ctrl;

    localparam int MSG_W = 64;
    localparam int PW    = MSG_W - 32;
    localparam int T     = 8;
    localparam int MR    = 2;

    typedef struct {
        logic [2:0]       st;
        logic [1:0]       att;
        logic [MSG_W-1:0] rsp;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       req_type = '0;
    logic [7:0]       req_param1 = '0;
    logic [7:0]       req_param2 = '0;
    logic [PW-1:0]    req_payload = '0;
    logic [MSG_W-1:0] msg_out;
    logic             msg_out_valid;
    logic             msg_out_ready = 1'b0;
    logic [MSG_W-1:0] msg_in = '0;
    logic             msg_in_valid = 1'b0;
    logic             msg_in_ready;
    logic             busy;
    logic             done;
    logic [2:0]       status;
    logic [MSG_W-1:0] rsp_out;
    logic [1:0]       attempts;
`ifdef AUTH_INIT_STATS_EN
    logic [15:0]      timeout_total;
    logic [15:0]      fail_total;
`endif

    exp_t             exp_q[$];
    logic [MSG_W-1:0] hs_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [MSG_W-1:0] last_rsp = '0;
    int               m_to = 0;
    int               m_fail = 0;

    always #5 clk = ~clk;

    auth_initiator_ctrl #(
        .MSG_W(MSG_W), .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .req_type(req_type), .req_param1(req_param1), .req_param2(req_param2), .req_payload(req_payload),
        .msg_out(msg_out), .msg_out_valid(msg_out_valid), .msg_out_ready(msg_out_ready),
        .msg_in(msg_in), .msg_in_valid(msg_in_valid), .msg_in_ready(msg_in_ready),
        .busy(busy), .done(done), .status(status), .rsp_out(rsp_out), .attempts(attempts)
`ifdef AUTH_INIT_STATS_EN
        , .timeout_total(timeout_total), .fail_total(fail_total)
`endif
    );

    task automatic chk(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference classification straight from the response rules
    function automatic logic [2:0] classify(input logic [MSG_W-1:0] r, input logic [7:0] t);
        if (r[7:0] != 8'h01) return 3'd3;
        if (r[15:8] == 8'h7F) return 3'd2;
        if (r[15:8] != (t & 8'h7F)) return 3'd4;
        return 3'd0;
    endfunction

    function automatic int rnd_delay();
        return ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, T - 1));
    endfunction

    // Monitor: checks every outgoing handshake and every completion against the queues
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (msg_out_valid && msg_out_ready) begin
                if (hs_q.size() == 0) chk("hs_unexpected", MSG_W'(msg_out_valid & msg_out_ready), '0);
                else chk("msg_out", msg_out, hs_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) chk("done_unexpected", MSG_W'(done), '0);
                else begin
                    e = exp_q.pop_front();
                    chk("status", MSG_W'(status), MSG_W'(e.st));
                    chk("attempts", MSG_W'(attempts), MSG_W'(e.att));
                    chk("rsp_out", rsp_out, e.rsp);
                    m_to   += int'(e.att) + ((e.st == 3'd1) ? 1 : 0);
                    m_fail += (e.st != 3'd0) ? 1 : 0;
                end
            end
        end
    end

    // One transaction: d0..d2 are response delays per attempt (-1 = stay silent)
    task automatic run_txn(input logic [7:0] t, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [PW-1:0] pl, input int rdly, input int d0, input int d1,
                           input int d2, input logic [MSG_W-1:0] r, input bit hold);
        int   d[3];
        int   k;
        int   g;
        exp_t e;
        d[0] = d0; d[1] = d1; d[2] = d2;
        k = 0;
        while (k <= MR && d[k] < 0) k++;
        if (k > MR) begin
            e.st = 3'd1; e.att = 2'(MR); e.rsp = last_rsp;
        end else begin
            e.st = classify(r, t); e.att = 2'(k); e.rsp = r; last_rsp = r;
        end
        exp_q.push_back(e);
        for (int i = 0; i <= ((k > MR) ? MR : k); i++) hs_q.push_back({pl, p2, p1, t, 8'h01});
        tick();
        start = 1'b1; req_type = t; req_param1 = p1; req_param2 = p2; req_payload = pl;
        tick();
        if (!hold) start = 1'b0;
        req_type = 8'($urandom); req_param1 = 8'($urandom); req_param2 = 8'($urandom); req_payload = PW'($urandom);
        for (int a = 0; a <= MR; a++) begin
            g = 0;
            while (!msg_out_valid && g < 50) begin tick(); g++; end
            if (!msg_out_valid) begin chk("send_wait", MSG_W'(msg_out_valid), MSG_W'(1)); break; end
            for (int i = 0; i < rdly; i++) begin
                tick();
                if (hold) begin req_type = 8'($urandom); req_param1 = 8'($urandom); end
            end
            msg_out_ready = 1'b1;
            tick();
            msg_out_ready = 1'b0;
            start = 1'b0;
            if (d[a] >= 0) begin
                for (int i = 0; i < d[a]; i++) tick();
                msg_in = r; msg_in_valid = 1'b1;
                tick();
                msg_in_valid = 1'b0; msg_in = {32'($urandom), 32'($urandom)};
                break;
            end
        end
        g = 0;
        while (busy && g < 60) begin tick(); g++; end
        chk("busy_drop", MSG_W'(busy), '0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, MSG_W'(busy), '0);
        chk({tag, "_done"}, MSG_W'(done), '0);
        chk({tag, "_valid"}, MSG_W'(msg_out_valid), '0);
        chk({tag, "_in_ready"}, MSG_W'(msg_in_ready), '0);
        chk({tag, "_status"}, MSG_W'(status), '0);
        chk({tag, "_attempts"}, MSG_W'(attempts), '0);
        chk({tag, "_msg_out"}, msg_out, '0);
        chk({tag, "_rsp_out"}, rsp_out, '0);
    endtask

`ifdef AUTH_INIT_STATS_EN
    task automatic check_stats();
        chk("timeout_total", MSG_W'(timeout_total), MSG_W'(m_to));
        chk("fail_total", MSG_W'(fail_total), MSG_W'(m_fail));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]       t;
        logic [7:0]       rv;
        logic [7:0]       rt;
        logic [MSG_W-1:0] r;
        int               c;
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        // Directed cases
        run_txn(8'h81, 8'h00, 8'h00, '0, 3, 5, -1, -1, 64'h0000_0101, 1'b0);
        run_txn(8'h82, 8'h11, 8'h22, 32'hCAFE_F00D, 1, -1, -1, -1, 64'h0, 1'b0);
        run_txn(8'h81, 8'h01, 8'h02, 32'h1234_5678, 0, 2, -1, -1, 64'h0000_7F01, 1'b0);
        run_txn(8'h81, 8'h01, 8'h02, 32'h1234_5678, 0, 2, -1, -1, 64'h0000_7F02, 1'b0);
        run_txn(8'h83, 8'h05, 8'h06, 32'hA5A5_5A5A, 2, 0, -1, -1, 64'hBEEF_0000_0000_0201, 1'b0);
        run_txn(8'h83, 8'h07, 8'h08, 32'h0BAD_BEEF, 0, T - 1, -1, -1, 64'h0000_0301, 1'b0);
        run_txn(8'h82, 8'h09, 8'h0A, 32'h5555_AAAA, 1, -1, T - 1, -1, 64'h0000_0201, 1'b0);
        run_txn(8'h81, 8'h33, 8'h44, 32'h0F0F_F0F0, 4, 3, -1, -1, 64'h0000_0101, 1'b1);
        // Responses offered while idle must be ignored
        msg_in = 64'hDEAD_BEEF_DEAD_7F02; msg_in_valid = 1'b1;
        tick();
        chk("in_ready_idle", MSG_W'(msg_in_ready), '0);
        tick(); tick();
        msg_in_valid = 1'b0;
        chk("rsp_idle", rsp_out, last_rsp);
        chk("busy_idle", MSG_W'(busy), '0);
        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            t  = 8'h81 + 8'($urandom_range(0, 2));
            rv = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01;
            c  = int'($urandom_range(0, 3));
            rt = (c == 0) ? 8'h7F : (c == 1) ? 8'($urandom) : (t & 8'h7F);
            r  = {32'($urandom), 16'($urandom), rt, rv};
            run_txn(t, 8'($urandom), 8'($urandom), PW'($urandom), int'($urandom_range(0, 3)),
                    rnd_delay(), rnd_delay(), rnd_delay(), r, 1'($urandom));
        end
`ifdef AUTH_INIT_STATS_EN
        check_stats();
`endif
        // Reset while waiting for a response aborts with no done pulse
        run_txn(8'h82, 8'h01, 8'h01, 32'h1, 0, -1, -1, -1, 64'h0, 1'b0);
        tick();
        start = 1'b1; req_type = 8'h83; req_param1 = 8'h44; req_param2 = 8'h55; req_payload = 32'h6677_8899;
        hs_q.push_back({32'h6677_8899, 8'h55, 8'h44, 8'h83, 8'h01});
        tick();
        start = 1'b0;
        msg_out_ready = 1'b1;
        tick();
        msg_out_ready = 1'b0;
        tick(); tick();
        chk("wait_in_ready", MSG_W'(msg_in_ready), MSG_W'(1));
        #3 reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        m_to = 0; m_fail = 0; last_rsp = '0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < T + 4; i++) begin
            tick();
            chk("no_done_after_reset", MSG_W'(done), '0);
        end
        run_txn(8'h81, 8'h00, 8'h00, 32'h0, 0, -1, 1, -1, 64'h0000_0101, 1'b0);
        run_txn(8'h82, 8'h00, 8'h00, 32'h0, 0, -1, -1, -1, 64'h0, 1'b0);
`ifdef AUTH_INIT_STATS_EN
        chk("timeout_total_plan", MSG_W'(timeout_total), 64'd4);
        check_stats();
`endif
        repeat (3) tick();
        chk("exp_q_left", MSG_W'(exp_q.size()), '0);
        chk("hs_q_left", MSG_W'(hs_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/auth_initiator_ctrl.md
Name: auth_initiator_ctrl

Overview:
Parametrised USB Type-C Authentication initiator controller. Builds a request message (ProtocolVersion/MessageType/Param1/Param2 header plus payload) and transmits it over a valid/ready handshake. It then waits for the responder's message under a cycle timeout, retries on timeout, and checks the response header. It sits between the host-side policy logic and the message transport, replacing the bare timeout counter of the first-generation initiator.

Parameters:
MSG_W, 1000, total message width in bits; header occupies bits [31:0], payload occupies [MSG_W-1:32]
TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_RSP per attempt (minimum 2)
MAX_RETRIES, 2, resends after the first attempt (0 = single attempt)
PROTOCOL_VERSION, 8'h01, value placed in request bits [7:0] and required in response bits [7:0]

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; accepted only when busy=0
req_type  in  8  request MessageType: 0x81 GET_DIGESTS, 0x82 GET_CERTIFICATE, 0x83 CHALLENGE
req_param1  in  8  Param1
req_param2  in  8  Param2
req_payload  in  MSG_W-32  payload, latched at start
msg_out  out  MSG_W  request message {payload, param2, param1, type, version}
msg_out_valid  out  1  request valid
msg_out_ready  in  1  transport accepts request
msg_in  in  MSG_W  response message
msg_in_valid  in  1  response valid
msg_in_ready  out  1  high only in WAIT_RSP
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at completion
status  out  3  0 OK, 1 TIMEOUT, 2 ERROR_RSP, 3 BAD_VERSION, 4 BAD_TYPE; held until next start
rsp_out  out  MSG_W  last captured response; held until next capture
attempts  out  2  retries used in the last transaction

Behaviour:
- Reset (async): state=IDLE; all outputs 0; internal counters and latched message cleared.
- IDLE: on start, latch the header and payload into msg_out, clear the retry count and status, go to SEND. A start asserted while busy is ignored.
- SEND: msg_out_valid=1. msg_out stays stable until msg_out_ready. On valid&&ready go to WAIT_RSP. There is no timeout in SEND.
- WAIT_RSP: the timeout counter clears on entry; msg_in_ready=1.
  - Each cycle, if msg_in_valid: capture msg_in into rsp_out and go to CHECK.
  - Else if cnt==TIMEOUT_CYCLES-1: timeout event.
  - Else cnt++.
  - A response is therefore accepted in any of the first TIMEOUT_CYCLES cycles; a response in the same cycle as the terminal count wins.
- Timeout event: if retries<MAX_RETRIES, retries++ and go to SEND, resending the identical message. Otherwise status=TIMEOUT and go to DONE.
- CHECK (1 cycle), first match wins:
  - rsp[7:0]!=PROTOCOL_VERSION gives BAD_VERSION.
  - rsp[15:8]==0x7F gives ERROR_RSP.
  - rsp[15:8]!=(req_type & 0x7F) gives BAD_TYPE.
  - Anything else gives OK.
  - Go to DONE.
- DONE (1 cycle): done=1, attempts=retries, go to IDLE. busy drops the cycle after done.
- msg_in_valid outside WAIT_RSP is ignored (msg_in_ready=0); no capture.
- Latency, SEND to WAIT_RSP: 1 cycle after handshake. Response capture to done: 2 cycles.
- Reset mid-transaction aborts immediately. No done pulse is generated.

Optional Feature:
AUTH_INIT_STATS_EN. When defined, adds outputs timeout_total[15:0] and fail_total[15:0]:
- timeout_total increments on every timeout event, including ones that trigger a retry.
- fail_total increments on every DONE with status!=OK.
- Both counters saturate at 0xFFFF and clear only on reset.
When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package auth_pkg holds:
  - MessageType constants (GET_DIGESTS, GET_CERTIFICATE, CHALLENGE, DIGESTS, CERTIFICATE, CHALLENGE_AUTH, ERROR=0x7F).
  - Status code constants.
  - The state enum.
  - Header field offsets.
- One sub-module is natural: auth_timeout_timer (clear, enable, terminal-count output, parameter TIMEOUT_CYCLES).

Test Plan:
- GET_DIGESTS, P1=0x00: msg_out[31:0]=0x00008101; ready after 3 cycles; response 0x00000101 at WAIT_RSP cycle 5 -> done, status=0, attempts=0.
- TIMEOUT_CYCLES=8, MAX_RETRIES=2, no response -> three SEND handshakes with identical msg_out; done after the third expiry, status=1, attempts=2.
- Response MessageType 0x7F -> status=2. Version 0x02 -> status=3, even though the type is also 0x7F.
- CHALLENGE with response type 0x02 -> status=4. Response on the terminal-count cycle -> accepted, status=0, no retry.
- start held while busy -> ignored. Reset asserted in WAIT_RSP -> all outputs 0 immediately and no done pulse. msg_in_valid in IDLE -> rsp_out unchanged.
- With AUTH_INIT_STATS_EN: one retry-then-OK transaction plus one full timeout -> timeout_total=4, fail_total=1.
